// File: rtl/issue_unit_scheduler.sv
// issue_unit_scheduler
//   Single-issue scheduler for the out-of-order back end. Each cycle it grants
//   at most one ready issue queue (int, mem, mul, div). It also books the
//   future CDB cycle in which the granted unit's result broadcasts, so no two
//   units ever drive the CDB in the same cycle.
//
// Ports
//   clk, reset                    clock (rising edge), async active-high reset
//   stall                         suppresses all grants; state still advances
//   int/mem/mul/div_ready         queue has a ready head entry
//   int/mem/mul/div_done          one-hot issue grant (queue pops on this edge)
//   grant_valid, grant_id         any grant / index of granted unit (0 if none)
//   cdb_slot_busy                 a booked result broadcasts this cycle
//   div_busy                      non-pipelined divider is occupied
module issue_unit_scheduler #(
  parameter int INT_LAT   = 1,
  parameter int MEM_LAT   = 2,
  parameter int MUL_LAT   = 4,
  parameter int DIV_LAT   = 6,
  parameter int RSV_DEPTH = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       stall,
  input  logic       int_ready,
  input  logic       mem_ready,
  input  logic       mul_ready,
  input  logic       div_ready,
  output logic       int_done,
  output logic       mem_done,
  output logic       mul_done,
  output logic       div_done,
  output logic       grant_valid,
  output logic [1:0] grant_id,
  output logic       cdb_slot_busy,
  output logic       div_busy
);

  localparam int CNT_W = $clog2(DIV_LAT + 1);
  localparam logic [RSV_DEPTH:0] ONE = 1;

  // rsv[k] set: a result is already booked for the CDB k cycles from now
  logic [RSV_DEPTH:0] rsv;
  logic [RSV_DEPTH:0] rsv_next;
  logic [RSV_DEPTH:0] set_mask;
  logic [1:0]         rr_ptr;
  logic [CNT_W-1:0]   div_cnt;
  logic [3:0]         elig;
  logic [3:0]         grant;
  logic [1:0]         gid;
  logic [1:0]         sel_idx;
  logic               found;

  // Eligibility: ready, own CDB slot free, divider idle. Reset forces the
  // grants low immediately rather than waiting for the next edge.
  always_comb begin
    elig    = '0;
    elig[0] = int_ready && !rsv[INT_LAT];
    elig[1] = mem_ready && !rsv[MEM_LAT];
    elig[2] = mul_ready && !rsv[MUL_LAT];
    elig[3] = div_ready && !rsv[DIV_LAT] && (div_cnt == '0);
    if (stall || reset) begin
      elig = '0;
    end
  end

  // Round-robin search starting at rr_ptr; first eligible unit wins
  always_comb begin
    grant   = '0;
    gid     = 2'd0;
    found   = 1'b0;
    sel_idx = 2'd0;
    for (int i = 0; i < 4; i++) begin
      sel_idx = rr_ptr + 2'(i);
      if (!found && elig[sel_idx]) begin
        grant[sel_idx] = 1'b1;
        gid            = sel_idx;
        found          = 1'b1;
      end
    end
  end

  // Booking lands at index L-1 because the whole window shifts on this edge
  always_comb begin
    set_mask = '0;
    case (gid)
      2'd0:    set_mask = ONE << (INT_LAT - 1);
      2'd1:    set_mask = ONE << (MEM_LAT - 1);
      2'd2:    set_mask = ONE << (MUL_LAT - 1);
      default: set_mask = ONE << (DIV_LAT - 1);
    endcase
    rsv_next = {1'b0, rsv[RSV_DEPTH:1]};
    if (found) begin
      rsv_next = rsv_next | set_mask;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rsv     <= '0;
      rr_ptr  <= 2'd0;
      div_cnt <= '0;
    end else begin
      rsv <= rsv_next;
      if (found) begin
        rr_ptr <= gid + 2'd1;
      end
      // Counter reaches zero exactly in the cycle the divide result broadcasts
      if (grant[3]) begin
        div_cnt <= CNT_W'(DIV_LAT - 1);
      end else if (div_cnt != '0) begin
        div_cnt <= div_cnt - CNT_W'(1);
      end
    end
  end

  assign int_done      = grant[0];
  assign mem_done      = grant[1];
  assign mul_done      = grant[2];
  assign div_done      = grant[3];
  assign grant_valid   = found;
  assign grant_id      = gid;
  assign cdb_slot_busy = rsv[0];
  assign div_busy      = (div_cnt != '0);

endmodule

// File: doc/issue_unit_scheduler.md
# issue_unit_scheduler

Single-issue scheduler for the out-of-order back end. Each cycle it picks at most one ready issue queue (integer, load/store, multiply, divide), pulses that queue's `issueblk_done`, and reserves the future CDB cycle in which the chosen unit's result will broadcast. This guarantees that no two units ever drive the CDB in the same cycle. It sits between the four issue queues and their execution units.

## Interface
- `INT_LAT`, 1, integer ALU result latency in cycles (grant to CDB broadcast)
- `MEM_LAT`, 2, load/store unit result latency
- `MUL_LAT`, 4, multiplier latency; the multiplier is pipelined
- `DIV_LAT`, 6, divider latency; the divider is not pipelined
- `RSV_DEPTH`, 8, CDB reservation window; every `*_LAT` is in 1..`RSV_DEPTH`
- `clk`  in  1  clock, rising edge
- `reset`  in  1  asynchronous, active-high
- `stall`  in  1  suppresses all grants this cycle; state still advances
- `int_ready`  in  1  integer queue has a ready head entry
- `mem_ready`  in  1  load/store queue has a ready head entry
- `mul_ready`  in  1  multiply queue has a ready head entry
- `div_ready`  in  1  divide queue has a ready head entry
- `int_done`  out  1  issue grant to the integer queue (drives its `issueblk_done`)
- `mem_done`  out  1  issue grant to the load/store queue
- `mul_done`  out  1  issue grant to the multiply queue
- `div_done`  out  1  issue grant to the divide queue
- `grant_valid`  out  1  OR of the four grants
- `grant_id`  out  2  0=int, 1=mem, 2=mul, 3=div; 0 when no grant
- `cdb_slot_busy`  out  1  a previously granted result broadcasts on the CDB this cycle
- `div_busy`  out  1  divider is occupied

## Operation
- State:
  - `rsv[0..RSV_DEPTH]` bit vector. `rsv[k]` = 1 in cycle t means a result is already scheduled for the CDB in cycle t+k.
  - `rr_ptr` (2 bits): round-robin pointer.
  - `div_cnt` (width = clog2(`DIV_LAT`+1)): divider occupancy counter.
- Eligibility of unit u with latency L_u in cycle t: `u_ready` && !`rsv[L_u]` && !`stall`. The divider additionally requires `div_cnt` == 0.
- Selection: among eligible units, search in order `rr_ptr`, `rr_ptr`+1, `rr_ptr`+2, `rr_ptr`+3 (mod 4) and grant the first one found.
- Grants are combinational from the current inputs and state.
  - Exactly zero or one `*_done` is high.
  - A unit is never granted unless its `*_ready` input is high.
- Reservation update at each clock edge:
  - `rsv'[k]` = `rsv[k+1]` | (`grant_valid` && L_granted == k+1), for k = 0..`RSV_DEPTH`-1.
  - `rsv'[RSV_DEPTH]` = 0.
  - Consequently a grant in cycle t with latency L makes `cdb_slot_busy` (= `rsv[0]`) high in cycle t+L.
- Round-robin: on a grant, `rr_ptr` <= `grant_id` + 1 (mod 4). With no grant, `rr_ptr` holds.
- Divider occupancy:
  - On a `div_done` edge, `div_cnt` <= `DIV_LAT`-1.
  - Otherwise, if `div_cnt` != 0, `div_cnt` decrements by 1.
  - `div_busy` = (`div_cnt` != 0).
  - The next divide can be granted in cycle t+`DIV_LAT`, the cycle in which the previous divide result broadcasts.
- `stall`:
  - Forces all grants to 0.
  - `rsv` still shifts and `div_cnt` still decrements, because in-flight results keep moving.
  - `rr_ptr` holds.

## Timing
- Reset (asynchronous, takes effect immediately):
  - `rsv` = 0, `rr_ptr` = 0, `div_cnt` = 0.
  - All `*_done`, `grant_valid`, `grant_id`, `cdb_slot_busy` and `div_busy` = 0.
- Grant latency: 0 cycles from `*_ready` to `*_done` in the same cycle. The queue pops its head at the same rising edge.
- Throughput: at most 1 grant per cycle. Back-to-back integer grants are legal every cycle because slot t+1 is shifted out before the next check.
- Conflict: a unit whose CDB slot is taken is skipped that cycle, not delayed. The next eligible unit in round-robin order is granted instead.
  - Example: a `MUL_LAT`=4 grant in cycle t blocks a `MEM_LAT`=2 grant in cycle t+2 and an `INT_LAT`=1 grant in cycle t+3.
- A ready request stays pending with no timeout. Round-robin bounds starvation only among eligible units; a slot conflict can delay a unit repeatedly.
- Reset mid-operation: all reservations and divider occupancy are discarded. Results already in flight are also flushed by the same reset.
- All `*_ready` low: no grant, and state only shifts and decrements.

## Test plan
- Reset, then `int_ready` held high for 5 cycles -> `int_done` high in all 5 cycles; `cdb_slot_busy` high in cycles 2..6.
- All four ready from reset, unit latencies default -> grant order int, mem, mul, div in consecutive cycles 1..4. `grant_id` follows the same order; `rr_ptr` returns to 0 after the div grant.
- Grant mul in cycle 0, then only `int_ready` from cycle 0 onward -> int granted in cycles 1, 2 and 4; int skipped in cycle 3 (slot 4 taken); `cdb_slot_busy` high in cycles 2, 3, 4 and 5.
- Grant div in cycle 0, `div_ready` held high -> `div_busy` high in cycles 1..5; next `div_done` in cycle 6.
- `stall` high for cycles 2..3 with all queues ready -> no grants in cycles 2..3; `cdb_slot_busy` pattern from earlier grants unchanged; grants resume in cycle 4 at the held `rr_ptr`.
- Assert `reset` in cycle 3 after a div grant in cycle 0 -> `div_busy`, `cdb_slot_busy` and all grants drop to 0 immediately; a div grant is possible in the first cycle after reset release.
